tdm_mux_8x1: RTL and testbench
==============================

# tdm_mux_8x1

Time-division serializer that accepts an 8-bit parallel word and transmits it one bit per clock on a single line. Alongside each bit it drives the 3-bit lane index `S`, so a downstream `demux_1x8` fed with `Dout`/`S` puts each bit back on its original lane. It is the transmit end of the 8-lane TDM link and sits between the parallel data source and the serial channel.

## Interface
- `IDLE_LEVEL`, default 1'b0: value driven on `Dout` whenever `Dout_valid`=0.
- `GAP_CYCLES`, default 0: idle cycles inserted after each frame, range 0..15.
- `clk` in 1: single clock; all logic on the rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `Din` in 8: parallel word; bit i is lane i.
- `Din_valid` in 1: `Din` holds a word to send.
- `Din_ready` out 1: block accepts a word this cycle.
- `Dout` out 1: serial data bit.
- `S` out 3: lane index of the bit currently on `Dout`.
- `Dout_valid` out 1: `Dout`/`S` carry a data or parity slot.
- `Frame_start` out 1: high only in the lane-0 slot.
- `Par_slot` out 1: high in the parity slot; tied 0 when parity is compiled out.

## Operation
- FSM states: IDLE, SEND, PAR (only with the macro), GAP.
- Handshake: a word is accepted on a rising edge where `Din_valid && Din_ready`. `Din` is copied into a holding register, so `Din` may change on the next cycle.
- `Din_ready` is a combinational decode of state. It is 1 in IDLE. It is also 1 in the final slot of a frame (lane 7, or PAR when enabled) if `GAP_CYCLES`=0. Otherwise it is 0. It is forced to 0 while `rst`=1.
- IDLE → SEND on accept. The lane counter is cleared to 0.
- SEND: each cycle `Dout`=hold[cnt], `S`=cnt, `Dout_valid`=1. The counter increments from 0 to 7 and does not wrap within a frame.
- At lane 7 the next state is:
  - PAR, if enabled;
  - GAP, if `GAP_CYCLES`>0;
  - SEND with a new word, if accepted this cycle;
  - IDLE otherwise.
- PAR: one cycle with `Dout`=^hold (even parity), `S`=3'd7, `Par_slot`=1, `Dout_valid`=1. It exits the same way lane 7 exits in the non-parity build.
- GAP: `GAP_CYCLES` cycles with `Dout`=`IDLE_LEVEL`, `Dout_valid`=0, `S`=0. A 4-bit down-counter controls the length. Then → IDLE.
- Bits go out LSB first (lane 0 first).

## Timing
- All outputs are registered except `Din_ready`.
- Reset values:
  - `Dout`=`IDLE_LEVEL`
  - `S`=0
  - `Dout_valid`=0
  - `Frame_start`=0
  - `Par_slot`=0
  - state=IDLE, counters=0
- Latency: accept at edge N → lane 0 is on the outputs after edge N+1.
- Frame period: 8 cycles, plus 1 with parity, plus `GAP_CYCLES`. When `GAP_CYCLES`=0, back-to-back words go out with no bubble.
- `Din_valid`=0 at the final slot with `GAP_CYCLES`=0 → IDLE. Outputs return to idle values on the next cycle.
- Reset mid-frame aborts the frame. The next cycle shows reset values and no partial frame resumes. A word offered during reset is not accepted.
- `Din_valid` deasserted while `Din_ready`=0 is legal; nothing is lost or duplicated.

## Configuration
- `TDM_MUX_PARITY_EN` defined: the PAR state exists and an even-parity slot follows lane 7 on every frame, with `Par_slot` marking it.
- `TDM_MUX_PARITY_EN` undefined: no PAR state, `Par_slot` is constant 0, and a frame is exactly 8 data slots.

## Structure
- Package `tdm_mux_pkg` holds:
  - the `LANES`=8 and `SEL_W`=3 constants;
  - the FSM state enum;
  - the `GAP_W`=4 counter width.
- Sub-module `mux_8x1`: combinational 8:1 bit selector taking (hold word, counter) and returning the selected bit. It is the counterpart of the receive-side demux.

## Test plan
- Reset, then `Din`=8'hA5 with valid for one cycle:
  - `Dout` = 1,0,1,0,0,1,0,1 with `S` = 0..7;
  - `Frame_start` high only on `S`=0;
  - then idle with `Dout_valid`=0.
- Valid held high continuously with 8'h0F followed by 8'hF0, `GAP_CYCLES`=0: 16 consecutive valid slots with no bubble, and `Din_ready` high exactly on the lane-7 cycles.
- `GAP_CYCLES`=3, two words offered back-to-back: exactly 3 cycles with `Dout_valid`=0 and `Dout`=`IDLE_LEVEL` between the frames.
- With `TDM_MUX_PARITY_EN`:
  - 8'h07 → 9th slot `Dout`=1 with `Par_slot`=1;
  - 8'hA5 → 9th slot `Dout`=0.
- `rst` pulsed at lane 4 of a frame:
  - the next cycle shows reset values;
  - the next accepted word starts at lane 0.
- Loopback into `demux_1x8` (its input gated by `Dout_valid`, outputs latched per slot): random 200 words are reconstructed bit-exact.

Source files
------------

// File: rtl/tdm_mux_pkg.sv
// Shared constants and the FSM state type for the 8-lane TDM transmit path.
//   LANES  - number of parallel lanes serialised per frame
//   SEL_W  - width of the lane index driven alongside each bit
//   GAP_W  - width of the inter-frame gap down-counter
//   state_t - serializer FSM states; PAR exists only when TDM_MUX_PARITY_EN is defined
package tdm_mux_pkg;

  localparam int LANES = 8;
  localparam int SEL_W = 3;
  localparam int GAP_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
`ifdef TDM_MUX_PARITY_EN
    ST_PAR  = 2'd2,
`endif
    ST_GAP  = 2'd3
  } state_t;

endpackage

// File: rtl/mux_8x1.sv
// Combinational 8:1 bit selector; transmit-side counterpart of demux_1x8.
//   data    in  8 : held parallel word, bit i is lane i
//   sel     in  3 : lane to forward
//   bit_out out 1 : data[sel]
module mux_8x1
  import tdm_mux_pkg::*;
(
  input  logic [LANES-1:0] data,
  input  logic [SEL_W-1:0] sel,
  output logic             bit_out
);

  assign bit_out = data[sel];

endmodule

// File: rtl/tdm_mux_8x1.sv
// Time-division serializer: accepts an 8-bit word and sends it LSB first,
// one bit per clock, with the lane index on S so a demux can rebuild it.
// Optional even-parity slot after lane 7 when TDM_MUX_PARITY_EN is defined.
//   clk, rst     : clock, synchronous active-high reset
//   Din          : parallel word (bit i = lane i), Din_valid/Din_ready handshake
//   Dout, S      : serial bit and its lane index (registered)
//   Dout_valid   : Dout/S carry a data or parity slot
//   Frame_start  : high in the lane-0 slot
//   Par_slot     : high in the parity slot (constant 0 without parity)
// Parameters: IDLE_LEVEL (Dout when not valid), GAP_CYCLES (0..15 idle slots per frame)
module tdm_mux_8x1
  import tdm_mux_pkg::*;
#(
  parameter logic IDLE_LEVEL = 1'b0,
  parameter int   GAP_CYCLES = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [LANES-1:0] Din,
  input  logic             Din_valid,
  output logic             Din_ready,
  output logic             Dout,
  output logic [SEL_W-1:0] S,
  output logic             Dout_valid,
  output logic             Frame_start,
  output logic             Par_slot
);

  localparam logic [SEL_W-1:0] LAST_LANE = SEL_W'(LANES - 1);
  // Outputs lag the state by one register stage, so the IDLE cycle in which
  // the next word is accepted is itself seen as an idle slot on the line.
  // The GAP state therefore lasts one cycle less than the visible gap.
  localparam logic [GAP_W-1:0] GAP_LOAD =
    (GAP_CYCLES > 1) ? GAP_W'(GAP_CYCLES - 1) : '0;

  state_t             state_reg, state_next;
  logic [SEL_W-1:0]   cnt_reg, cnt_next;
  logic [GAP_W-1:0]   gap_reg, gap_next;
  logic [LANES-1:0]   hold_reg, hold_next;

  logic               dout_reg, dout_next;
  logic [SEL_W-1:0]   s_reg, s_next;
  logic               valid_reg, valid_next;
  logic               fs_reg, fs_next;

  logic               last_slot;
  logic               accept;
  logic               frame_end;
  logic               sel_bit;

  mux_8x1 u_mux (
    .data    (hold_reg),
    .sel     (cnt_reg),
    .bit_out (sel_bit)
  );

`ifdef TDM_MUX_PARITY_EN
  assign last_slot = (state_reg == ST_PAR);
`else
  assign last_slot = (state_reg == ST_SEND) && (cnt_reg == LAST_LANE);
`endif

  assign Din_ready = !rst && ((state_reg == ST_IDLE) ||
                              ((GAP_CYCLES == 0) && last_slot));
  assign accept    = Din_valid && Din_ready;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    gap_next   = gap_reg;
    hold_next  = hold_reg;
    frame_end  = 1'b0;

    dout_next  = IDLE_LEVEL;
    s_next     = '0;
    valid_next = 1'b0;
    fs_next    = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          state_next = ST_SEND;
          cnt_next   = '0;
          hold_next  = Din;
        end
      end
      ST_SEND: begin
        dout_next  = sel_bit;
        s_next     = cnt_reg;
        valid_next = 1'b1;
        fs_next    = (cnt_reg == '0);
        if (cnt_reg == LAST_LANE) begin
`ifdef TDM_MUX_PARITY_EN
          state_next = ST_PAR;
`else
          frame_end  = 1'b1;
`endif
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
`ifdef TDM_MUX_PARITY_EN
      ST_PAR: begin
        dout_next  = ^hold_reg;
        s_next     = LAST_LANE;
        valid_next = 1'b1;
        frame_end  = 1'b1;
      end
`endif
      ST_GAP: begin
        if (gap_reg <= 1) begin
          state_next = ST_IDLE;
          gap_next   = '0;
        end else begin
          gap_next = gap_reg - 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase

    // Common exit from the final slot of a frame.
    if (frame_end) begin
      if (GAP_CYCLES > 1) begin
        state_next = ST_GAP;
        gap_next   = GAP_LOAD;
      end else if (accept) begin
        state_next = ST_SEND;
        cnt_next   = '0;
        hold_next  = Din;
      end else begin
        state_next = ST_IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      gap_reg   <= '0;
      hold_reg  <= '0;
      dout_reg  <= IDLE_LEVEL;
      s_reg     <= '0;
      valid_reg <= 1'b0;
      fs_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      gap_reg   <= gap_next;
      hold_reg  <= hold_next;
      dout_reg  <= dout_next;
      s_reg     <= s_next;
      valid_reg <= valid_next;
      fs_reg    <= fs_next;
    end
  end

`ifdef TDM_MUX_PARITY_EN
  logic ps_reg;
  always_ff @(posedge clk) begin
    if (rst) ps_reg <= 1'b0;
    else     ps_reg <= (state_reg == ST_PAR);
  end
  assign Par_slot = ps_reg;
`else
  assign Par_slot = 1'b0;
`endif

  assign Dout        = dout_reg;
  assign S           = s_reg;
  assign Dout_valid  = valid_reg;
  assign Frame_start = fs_reg;

endmodule

// File: tb/tb_tdm_mux_8x1.sv
module tb_tdm_mux_8x1;

`ifdef TDM_MUX_PARITY_EN
  localparam int PAR_SLOTS = 1;
`else
  localparam int PAR_SLOTS = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: GAP_CYCLES=0, IDLE_LEVEL=0
  logic       rst_a = 1'b1;
  logic [7:0] din_a = 8'h00;
  logic       vld_a = 1'b0;
  logic       rdy_a, dout_a, dv_a, fs_a, ps_a;
  logic [2:0] s_a;

  // Instance B: GAP_CYCLES=3, IDLE_LEVEL=1
  logic       rst_b = 1'b1;
  logic [7:0] din_b = 8'h00;
  logic       vld_b = 1'b0;
  logic       rdy_b, dout_b, dv_b, fs_b, ps_b;
  logic [2:0] s_b;

  tdm_mux_8x1 #(.IDLE_LEVEL(1'b0), .GAP_CYCLES(0)) dut_a (
    .clk(clk), .rst(rst_a), .Din(din_a), .Din_valid(vld_a), .Din_ready(rdy_a),
    .Dout(dout_a), .S(s_a), .Dout_valid(dv_a), .Frame_start(fs_a), .Par_slot(ps_a)
  );

  tdm_mux_8x1 #(.IDLE_LEVEL(1'b1), .GAP_CYCLES(3)) dut_b (
    .clk(clk), .rst(rst_b), .Din(din_b), .Din_valid(vld_b), .Din_ready(rdy_b),
    .Dout(dout_b), .S(s_b), .Dout_valid(dv_b), .Frame_start(fs_b), .Par_slot(ps_b)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard for instance A ----------------
  logic [7:0] exp_q[$];
  always @(posedge clk) begin
    if (vld_a && rdy_a) exp_q.push_back(din_a);
  end

  // Receive-side model: demux_1x8 gated by Dout_valid, latching each lane.
  int         lane_a = 0;
  logic [7:0] acc_a = 8'h00;
  bit         par_pend_a = 0;
  int         words_a = 0;
  int         run_a = 0;
  int         last_run_a = 0;
  logic       prev_rdy_a = 1'b0;
  logic       prev_rst_a = 1'b1;
  bit         have_prev_a = 0;

  task automatic finish_word_a();
    check("word_expected", (exp_q.size() != 0), 1);
    if (exp_q.size() != 0) begin
      check("word", acc_a, exp_q[0]);
      $display("word %0d: sent %02h rebuilt %02h", words_a, exp_q[0], acc_a);
      void'(exp_q.pop_front());
    end
    words_a++;
  endtask

  always @(negedge clk) begin
    logic final_a;
`ifdef TDM_MUX_PARITY_EN
    final_a = ps_a;
`else
    final_a = dv_a && (s_a == 3'd7);
`endif
    // Ready in one cycle predicts the slot presented in the next one:
    // high exactly when the line goes idle or the final slot follows.
    if (have_prev_a)
      check("din_ready", prev_rdy_a, (!prev_rst_a && (!dv_a || final_a)));

    if (prev_rst_a) begin
      lane_a = 0;
      par_pend_a = 0;
      exp_q.delete();
    end

    if (dv_a) begin
      run_a++;
      if (par_pend_a) begin
        check("par_flag", ps_a, 1);
        check("par_s", s_a, 7);
        check("par_fs", fs_a, 0);
        if (exp_q.size() != 0) check("par_bit", dout_a, ^exp_q[0]);
        par_pend_a = 0;
        finish_word_a();
      end else begin
        check("par_flag_low", ps_a, 0);
        if (lane_a == 0) check("frame_expected", (exp_q.size() != 0), 1);
        check("lane", s_a, lane_a);
        check("frame_start", fs_a, (lane_a == 0));
        acc_a[lane_a] = dout_a;
        lane_a++;
        if (lane_a == 8) begin
          lane_a = 0;
          if (PAR_SLOTS != 0) par_pend_a = 1;
          else finish_word_a();
        end
      end
    end else begin
      if (run_a > 0) last_run_a = run_a;
      run_a = 0;
      check("idle_dout", dout_a, 0);
      check("idle_s", s_a, 0);
      check("idle_fs", fs_a, 0);
      check("idle_ps", ps_a, 0);
      check("frame_broken", lane_a + (par_pend_a ? 1 : 0), 0);
      lane_a = 0;
      par_pend_a = 0;
    end

    prev_rdy_a = rdy_a;
    prev_rst_a = rst_a;
    have_prev_a = 1;
  end

  // ---------------- gap monitor for instance B ----------------
  int   gap_run_b = 0;
  int   last_gap_b = -1;
  bit   seen_frame_b = 0;
  logic prev_rdy_b = 1'b0;

  always @(negedge clk) begin
    if (!rst_b) begin
      check("b_ready_then_idle", (prev_rdy_b && dv_b), 0);
      if (!dv_b) begin
        check("b_idle_level", dout_b, 1);
        gap_run_b++;
      end else begin
        if (seen_frame_b && gap_run_b > 0) begin
          last_gap_b = gap_run_b;
          $display("instance B: %0d idle slots between frames", gap_run_b);
        end
        gap_run_b = 0;
        seen_frame_b = 1;
      end
    end
    prev_rdy_b = rdy_b;
  end

  // ---------------- stimulus ----------------
  task automatic send_a(input logic [7:0] w, input bit keep_valid);
    bit ok = 0;
    din_a = w;
    vld_a = 1'b1;
    for (int i = 0; i < 64 && !ok; i++) begin
      @(negedge clk);
      ok = rdy_a;
      @(posedge clk);
      #1;
    end
    if (!ok) check("accept_timeout_a", 0, 1);
    if (!keep_valid) begin
      vld_a = 1'b0;
      din_a = 8'($urandom);
    end
  endtask

  task automatic send_b(input logic [7:0] w, input bit keep_valid);
    bit ok = 0;
    din_b = w;
    vld_b = 1'b1;
    for (int i = 0; i < 64 && !ok; i++) begin
      @(negedge clk);
      ok = rdy_b;
      @(posedge clk);
      #1;
    end
    if (!ok) check("accept_timeout_b", 0, 1);
    if (!keep_valid) begin
      vld_b = 1'b0;
      din_b = 8'($urandom);
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit hit;
    idle_cycles(3);
    rst_a = 1'b0;
    rst_b = 1'b0;
    idle_cycles(2);

    // Single word A5, then idle
    send_a(8'hA5, 0);
    idle_cycles(12);

    // Parity reference words
    send_a(8'h07, 0);
    idle_cycles(12);
    send_a(8'hA5, 0);
    idle_cycles(12);

    // Back-to-back, valid held high
    send_a(8'h0F, 1);
    send_a(8'hF0, 0);
    idle_cycles(24);
    check("b2b_run", last_run_a, 2 * (8 + PAR_SLOTS));

    // Gap instance: two words offered back-to-back
    send_b(8'h3C, 1);
    send_b(8'hC3, 0);
    idle_cycles(30);
    check("gap_len", last_gap_b, 3);

    // Reset at lane 4; a word offered during reset must be ignored
    send_a(8'h5A, 0);
    hit = 0;
    for (int i = 0; i < 40 && !hit; i++) begin
      @(negedge clk);
      hit = dv_a && (s_a == 3'd4);
    end
    check("reach_lane4", hit, 1);
    rst_a = 1'b1;
    din_a = 8'hFF;
    vld_a = 1'b1;
    @(posedge clk);
    #1;
    rst_a = 1'b0;
    vld_a = 1'b0;
    idle_cycles(4);
    send_a(8'h96, 0);
    idle_cycles(12);

    // Random stream: 200 words with random spacing and occasional held valid
    for (int n = 0; n < 200; n++) begin
      send_a(8'($urandom), ($urandom_range(0, 1) == 1));
      if ($urandom_range(0, 3) == 0) begin
        vld_a = 1'b0;
        idle_cycles($urandom_range(1, 4));
      end
    end
    vld_a = 1'b0;
    idle_cycles(20);
    check("drain", exp_q.size(), 0);
    check("word_count", words_a, 206);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
